// File: rtl/mux4_scan_ctrl.sv
// mux4_scan_ctrl: upstream sequencer for the 4:1 decoder/tristate mux.
// It steps {s1,s0} through channels 0..3 and holds each channel for DWELL
// cycles. The mux output y_in is sampled at the end of each dwell, and the
// four samples are packed into a frame. The frame is then offered downstream
// on a valid/ready handshake.
//
// Optional feature: define MUX4_SCAN_CONT_EN for continuous scan mode. In that
// mode the HOLD handshake restarts a scan instead of returning to IDLE.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; sel parked at channel 0
// SCAN  | stepping channels, dwell_cnt counts cycles on current channel
// HOLD  | frame_valid high, waiting for frame_ready

`timescale 1ns/1ps

module mux4_scan_ctrl #(
    parameter int DWELL = 3,
    parameter int CNT_W = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       s1,
    output logic       s0,
    input  logic       y_in,
    output logic [3:0] frame,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Last dwell count on a channel; y_in is captured on this count.
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

    state_t           state;
    logic [1:0]       sel;
    logic [CNT_W-1:0] dwell_cnt;
    logic [2:0]       shadow;

    // The select lines come straight from the sel register, so s1/s0 are
    // glitch-free while the mux settles.
    assign s1 = sel[1];
    assign s0 = sel[0];

    // Scan sequencer: channel stepping, sample capture and output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sel         <= 2'd0;
            dwell_cnt   <= '0;
            shadow      <= 3'd0;
            frame       <= 4'h0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SCAN;
                        sel       <= 2'd0;
                        dwell_cnt <= '0;
                        busy      <= 1'b1;
                    end
                end

                SCAN: begin
                    if (dwell_cnt == DWELL_LAST) begin
                        dwell_cnt <= '0;
                        if (sel != 2'd3) begin
                            case (sel)
                                2'd0:    shadow[0] <= y_in;
                                2'd1:    shadow[1] <= y_in;
                                default: shadow[2] <= y_in;
                            endcase
                            sel <= sel + 2'd1;
                        end else begin
                            // Channel 3 goes directly into the frame, not
                            // through shadow. This lets frame_valid rise on
                            // the same edge as the final sample.
                            frame       <= {y_in, shadow};
                            frame_valid <= 1'b1;
                            sel         <= 2'd0;
                            state       <= HOLD;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + CNT_W'(1);
                    end
                end

                HOLD: begin
                    if (frame_ready) begin
                        frame_valid <= 1'b0;
`ifdef MUX4_SCAN_CONT_EN
                        state       <= SCAN;
                        sel         <= 2'd0;
                        dwell_cnt   <= '0;
`else
                        state       <= IDLE;
                        busy        <= 1'b0;
`endif
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Testbench for mux4_scan_ctrl. A small behavioural 4:1 mux drives y_in from
// mux_in and the select lines. Expected frames go into a scoreboard queue when
// a scan is launched. A negedge monitor pops and compares on every handshake.
// When MUX4_SCAN_CONT_EN is defined, the continuous-mode sequence runs instead
// of the single-shot sequence.

`timescale 1ns/1ps

module tb_mux4_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       s1;
    logic       s0;
    logic       y_in;
    logic [3:0] frame;
    logic       frame_valid;
    logic       frame_ready;
    logic       busy;

    logic [3:0] mux_in;
    logic [3:0] sb[$];
    logic [3:0] mon_exp;
    int         total;
    int         bad;

    mux4_scan_ctrl #(.DWELL(3), .CNT_W(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .s1          (s1),
        .s0          (s0),
        .y_in        (y_in),
        .frame       (frame),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .busy        (busy)
    );

    // Mux model: y follows the selected input combinationally.
    assign y_in = mux_in[{s1, s0}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a handshake completes at the next edge, so pop once per valid&ready.
    always @(negedge clk) begin
        if (rst_n && frame_valid && frame_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame actual=%0d required=none", frame);
            end else begin
                mon_exp = sb.pop_front();
                chk("sb_frame", {28'd0, frame}, {28'd0, mon_exp});
            end
        end
    end

    // Launch one scan and run it until frame_valid, or time out.
    task automatic do_scan(input logic [3:0] pat, input bit chk_seq, input bit mid_start);
        int  lat;
        bit  seq_ok;
        sb.push_back(pat);
        mux_in = pat;
        start  = 1'b1;
        step();
        start  = 1'b0;
        if (chk_seq) begin
            chk("busy_rise", {31'd0, busy}, 32'd1);
            chk("sel_first", {30'd0, s1, s0}, 32'd0);
        end
        lat    = 0;
        seq_ok = 1'b1;
        while (!frame_valid && lat < 40) begin
            start = mid_start && (lat == 4);
            step();
            lat++;
            if (chk_seq && !frame_valid && ({30'd0, s1, s0} != 32'(lat / 3)))
                seq_ok = 1'b0;
        end
        start = 1'b0;
        chk("latency", 32'(lat), 32'd12);
        if (chk_seq) chk("sel_seq", {31'd0, seq_ok}, 32'd1);
    endtask

    // One edge with frame_ready already high completes the handshake.
    task automatic finish_hs(input logic [3:0] pat);
        step();
        chk("valid_fall", {31'd0, frame_valid}, 32'd0);
        chk("busy_fall", {31'd0, busy}, 32'd0);
        chk("frame_kept", {28'd0, frame}, {28'd0, pat});
    endtask

    task automatic reset_mid_scan();
        bit quiet;
        mux_in = 4'b1010;
        start  = 1'b1;
        step();
        start  = 1'b0;
        repeat (6) step();
        chk("rst_pre_sel", {30'd0, s1, s0}, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_sel", {30'd0, s1, s0}, 32'd0);
        chk("rst_async_busy", {31'd0, busy}, 32'd0);
        chk("rst_async_frame", {28'd0, frame}, 32'd0);
        chk("rst_async_valid", {31'd0, frame_valid}, 32'd0);
        step();
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (14) begin
            step();
            if (frame_valid || busy) quiet = 1'b0;
        end
        chk("rst_no_valid", {31'd0, quiet}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hold_ok;
        int n;
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        frame_ready = 1'b1;
        mux_in      = 4'b0000;
        #3;
        chk("reset_sel", {30'd0, s1, s0}, 32'd0);
        chk("reset_frame", {28'd0, frame}, 32'd0);
        chk("reset_valid", {31'd0, frame_valid}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

`ifdef MUX4_SCAN_CONT_EN
        // Continuous mode: one start, then back-to-back frames.
        frame_ready = 1'b1;
        do_scan(4'b0011, 1'b1, 1'b0);
        sb.push_back(4'b1100);
        mux_in = 4'b1100;
        step();
        chk("cont_busy", {31'd0, busy}, 32'd1);
        chk("cont_valid_fall", {31'd0, frame_valid}, 32'd0);
        chk("cont_sel_restart", {30'd0, s1, s0}, 32'd0);
        n = 0;
        while (!frame_valid && n < 40) begin
            step();
            n++;
        end
        chk("cont_spacing", 32'(n), 32'd12);
        step();
        chk("cont_busy_after", {31'd0, busy}, 32'd1);
        reset_mid_scan();
`else
        // Basic scan of 1010 with the select sequence checked.
        frame_ready = 1'b1;
        do_scan(4'b1010, 1'b1, 1'b0);
        finish_hs(4'b1010);

        // Back-pressure: the frame must hold while the inputs change.
        frame_ready = 1'b0;
        do_scan(4'b1010, 1'b0, 1'b0);
        mux_in  = 4'b0101;
        hold_ok = 1'b1;
        repeat (6) begin
            step();
            if (!(frame_valid === 1'b1 && frame === 4'b1010)) hold_ok = 1'b0;
        end
        chk("bp_hold", {31'd0, hold_ok}, 32'd1);
        frame_ready = 1'b1;
        step();
        chk("bp_valid_fall", {31'd0, frame_valid}, 32'd0);
        chk("bp_busy_fall", {31'd0, busy}, 32'd0);

        // start is ignored mid-SCAN, during HOLD and at the handshake edge.
        frame_ready = 1'b0;
        do_scan(4'b1010, 1'b1, 1'b1);
        start = 1'b1;
        step();
        step();
        chk("hold_start_valid", {31'd0, frame_valid}, 32'd1);
        frame_ready = 1'b1;
        step();
        start = 1'b0;
        chk("hs_start_busy", {31'd0, busy}, 32'd0);
        hold_ok = 1'b1;
        repeat (4) begin
            step();
            if (busy || frame_valid) hold_ok = 1'b0;
        end
        chk("no_requeue", {31'd0, hold_ok}, 32'd1);

        // Async reset mid-scan, then a clean scan.
        reset_mid_scan();
        do_scan(4'b1010, 1'b1, 1'b0);
        finish_hs(4'b1010);

        // All 16 input patterns.
        for (int p = 0; p < 16; p++) begin
            do_scan(4'(p), 1'b0, 1'b0);
            finish_hs(4'(p));
        end
`endif
        step();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
